mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit for the EX stage. Replaces the fixed 32-bit divide-only helper.
- Handles MULT, MULTU, DIV and DIVU over DATA_W-bit operands, one radix-2 step per cycle.
- Returns a 2*DATA_W result in HI/LO layout.
- EX holds start_i high and stalls the pipeline until ready_o pulses; annul_i is the flush/cancel input that aborts a running operation.

Parameters:
- DATA_W, 32, operand width; even, ≥4.
- ZERO_SHORTCUT, 1, when 1 a multiply with either operand 0 completes without iterating.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  request; sampled only in IDLE.
- op_i  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start_i.
- opdata1_i  in  DATA_W  multiplicand / dividend.
- opdata2_i  in  DATA_W  multiplier / divisor.
- annul_i  in  1  cancel current operation.
- result_o  out  2*DATA_W  mult: {hi,lo} product; div: {remainder,quotient}.
- ready_o  out  1  one-cycle pulse, result_o valid.
- busy_o  out  1  high in RUN and DONE.
- dbz_o  out  1  divide-by-zero flag; valid with ready_o.

Behaviour:
- Reset (rst=1 at an edge, any state): state←IDLE, result_o←0, ready_o←0, busy_o←0, dbz_o←0, counter←0.
- rst has priority over annul_i, which has priority over start_i.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 and annul_i=0 → latch op and operands, then branch.
  - DIV/DIVU with opdata2_i==0 → DONE: result_o←0, dbz_o←1.
  - MULT/MULTU with an operand 0 and ZERO_SHORTCUT=1 → DONE: result_o←0, dbz_o←0.
  - Otherwise → RUN: counter←0, dbz_o←0.
- Signed ops (MULT, DIV):
  - Operands converted to magnitudes before iterating (two's-complement negate if MSB set).
  - Sign bits of both operands saved.
- RUN:
  - One iteration per edge, counter increments.
  - Multiply: shift-add, 2*DATA_W accumulator.
  - Divide: restoring shift-subtract; DATA_W+1-bit partial remainder compare.
  - On the edge where counter==DATA_W-1, final sign fix is applied and the result registered into result_o; state→DONE.
- Sign fix:
  - MULT product negated (2*DATA_W wide) when operand signs differ.
  - DIV quotient negated when signs differ; remainder takes the dividend's sign.
  - Unsigned ops get no fix.
- DONE: ready_o=1 for exactly this cycle; next edge → IDLE. start_i is ignored in DONE.
- ready_o is registered and high only in DONE.
- result_o and dbz_o hold their value until the next accepted start or rst.
- Latency (edge that samples start_i = edge 1):
  - Iterating op: ready_o is high in the cycle after edge DATA_W+1; 33 edges for DATA_W=32.
  - Shortcut/DBZ: ready_o is high after edge 1.
- Overflow case: DIV most-negative / −1 gives quotient = most-negative, remainder 0 (W-bit wrap), no flag.
- annul_i=1 in RUN or DONE:
  - → IDLE at that edge; ready_o←0, busy_o←0.
  - result_o is not updated by the aborted op.
  - A start_i in the same cycle is not accepted.
- annul_i in IDLE has no effect beyond blocking start.
- busy_o is 1 in RUN and DONE, 0 in IDLE.
- start_i held high continuously after DONE launches a new operation from IDLE. EX must drop start_i in the ready cycle to avoid a re-launch.

Test Plan (DATA_W=32):
- MULT 0xFFFFFFFE × 0x00000003 → ready after edge 33, result_o=0xFFFFFFFF_FFFFFFFA, dbz_o=0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → result_o=0xFFFFFFFE_00000001; ready_o is high for exactly one cycle.
- DIV 0xFFFFFFF9 (−7) / 0x00000002 → result_o={0xFFFFFFFF,0xFFFFFFFD}. Also DIV 0x80000000 / 0xFFFFFFFF → {0x00000000,0x80000000}.
- DIVU 0x00000064 / 0 → ready_o after edge 1, dbz_o=1, result_o=0. Then MULTU 0 × 5 with ZERO_SHORTCUT=1 → ready after edge 1, result 0, dbz_o=0.
- DIVU 0x00000064 / 0x00000007 with annul_i pulsed at edge 10:
  - busy_o=0 next cycle, no ready_o, result_o unchanged.
  - Immediate DIVU 0x00000064 / 0x00000007 → {0x00000002,0x0000000E}.
- rst asserted at edge 20 of a MULT → all outputs 0 after that edge. A subsequent MULTU 3 × 4 gives 0x00000000_0000000C.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 MULT/MULTU/DIV/DIVU with a {hi,lo} result.
// Multiply and divide share one 2*DATA_W accumulator: {hi,lo} product or {remainder,quotient}.
module mul_div_unit #(
    parameter int DATA_W        = 32,
    parameter bit ZERO_SHORTCUT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  dbz_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int CW = $clog2(DATA_W);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                is_div, neg_res, neg_rem;
    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] acc;

    logic                s1, s2;
    logic [DATA_W-1:0]   mag1, mag2;
    logic [DATA_W:0]     msum, rsh, diff;
    logic [2*DATA_W-1:0] nx, fixed;

    always_comb begin
        s1    = op_i[0] & opdata1_i[DATA_W-1];
        s2    = op_i[0] & opdata2_i[DATA_W-1];
        mag1  = s1 ? -opdata1_i : opdata1_i;
        mag2  = s2 ? -opdata2_i : opdata2_i;
        msum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : '0);
        // restoring step: shift the next dividend bit into the partial remainder
        rsh   = acc[2*DATA_W-1:DATA_W-1];
        diff  = rsh - {1'b0, mcand};
        nx    = is_div ? {diff[DATA_W] ? rsh[DATA_W-1:0] : diff[DATA_W-1:0], acc[DATA_W-2:0], ~diff[DATA_W]}
                       : {msum, acc[DATA_W-1:1]};
        fixed = !is_div ? (neg_res ? -nx : nx)
                        : {neg_rem ? -nx[2*DATA_W-1:DATA_W] : nx[2*DATA_W-1:DATA_W],
                           neg_res ? -nx[DATA_W-1:0] : nx[DATA_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
            dbz_o    <= 1'b0;
            cnt      <= '0;
        end else if (annul_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    is_div  <= op_i[1];
                    neg_res <= s1 ^ s2;
                    neg_rem <= op_i[1] & s1;
                    mcand   <= op_i[1] ? mag2 : mag1;
                    acc     <= {{DATA_W{1'b0}}, op_i[1] ? mag1 : mag2};
                    busy_o  <= 1'b1;
                    if (op_i[1] && opdata2_i == '0) begin
                        state    <= DONE;
                        ready_o  <= 1'b1;
                        result_o <= '0;
                        dbz_o    <= 1'b1;
                    end else if (!op_i[1] && ZERO_SHORTCUT && (opdata1_i == '0 || opdata2_i == '0)) begin
                        state    <= DONE;
                        ready_o  <= 1'b1;
                        result_o <= '0;
                        dbz_o    <= 1'b0;
                    end else begin
                        state <= RUN;
                        cnt   <= '0;
                        dbz_o <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DATA_W-1)) begin
                        state    <= DONE;
                        ready_o  <= 1'b1;
                        result_o <= fixed;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table plus annul and mid-operation reset sequences.
module tb_mul_div_unit;
    logic        clk = 0, rst = 1, start_i = 0, annul_i = 0;
    logic [1:0]  op_i = 0;
    logic [31:0] opdata1_i = 0, opdata2_i = 0;
    logic [63:0] result_o;
    logic        ready_o, busy_o, dbz_o;
    int          n_pass = 0, n_total = 0;

    mul_div_unit #(.DATA_W(32), .ZERO_SHORTCUT(1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o), .dbz_o(dbz_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] res;
        logic        dbz;
        int          lat;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_i = op; opdata1_i = a; opdata2_i = b; start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
    endtask

    task automatic run_op(input string name, input vec_t v);
        int n;
        launch(v.op, v.a, v.b);
        n = 1;
        while (!ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, 64'(n), 64'(v.lat));
        check({name, " result"}, result_o, v.res);
        check({name, " dbz"}, 64'(dbz_o), 64'(v.dbz));
        check({name, " busy_in_done"}, 64'(busy_o), 64'd1);
        @(posedge clk); #1;
        check({name, " ready_pulse"}, 64'(ready_o), 64'd0);
        check({name, " busy_idle"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        logic [63:0] prev;
        int          rdy_cnt;
        vecs[0]  = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA, 1'b0, 33};
        vecs[1]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 33};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 33};
        vecs[3]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 33};
        vecs[4]  = '{2'b10, 32'h00000064, 32'h00000000, 64'h0, 1'b1, 1};
        vecs[5]  = '{2'b00, 32'h00000000, 32'h00000005, 64'h0, 1'b0, 1};
        vecs[6]  = '{2'b10, 32'h00000064, 32'h00000007, 64'h00000002_0000000E, 1'b0, 33};
        vecs[7]  = '{2'b01, 32'h00000007, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 33};
        vecs[8]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 33};
        vecs[9]  = '{2'b00, 32'h00000003, 32'h00000004, 64'h00000000_0000000C, 1'b0, 33};
        vecs[10] = '{2'b11, 32'h00000000, 32'h00000005, 64'h0, 1'b0, 33};

        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("reset result", result_o, 64'h0);
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset dbz", 64'(dbz_o), 64'd0);

        foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);

        // annul a DIVU at edge 10; the result from the previous op must survive
        prev = result_o;
        launch(2'b10, 32'h64, 32'h7);
        repeat (8) @(posedge clk);
        #1 annul_i = 1;
        @(posedge clk); #1;
        annul_i = 0;
        check("annul busy", 64'(busy_o), 64'd0);
        check("annul ready", 64'(ready_o), 64'd0);
        check("annul result", result_o, prev);
        rdy_cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o) rdy_cnt++;
        end
        check("annul no_ready", 64'(rdy_cnt), 64'd0);
        run_op("after_annul", vecs[6]);

        // reset at edge 20 of a MULT
        launch(2'b01, 32'hFFFFFFFE, 32'h3);
        repeat (18) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("midrst result", result_o, 64'h0);
        check("midrst ready", 64'(ready_o), 64'd0);
        check("midrst busy", 64'(busy_o), 64'd0);
        check("midrst dbz", 64'(dbz_o), 64'd0);
        run_op("after_rst", vecs[9]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
